// File: rtl/arbitro_interfaces.sv
// Registered N-way arbiter for function-2 requests from the interface modules.
// Drives the select of the code-forwarding mux with a latched, releasable grant.
module arbitro_interfaces #(
    parameter int N        = 4,
    parameter int IDW      = $clog2(N),
    parameter int MODE     = 0,
    parameter int HOLD_MAX = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic           ativo,
    output logic [IDW-1:0] sel,
    output logic [N-1:0]   grant
);

    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] CMAX = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    typedef enum logic [1:0] {
        OCIOSO,
        CONCEDIDO,
        LIBERA
    } estado_t;

    estado_t        st;
    estado_t        st_d;
    logic [IDW-1:0] ult;
    logic [IDW-1:0] venc;
    logic [IDW-1:0] ix;
    logic [CW-1:0]  cnt;
    int             j;
    logic           achou;
    logic           outros;
    logic           limite;
    logic           soltar;
    logic           ativo_d;
    logic [IDW-1:0] sel_d;
    logic [N-1:0]   grant_d;

    // Winner: highest index in fixed mode, first set bit after ult in RR.
    always_comb begin
        venc  = '0;
        ix    = '0;
        j     = 0;
        achou = 1'b0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                ix = IDW'(i);
                if (req[ix]) venc = ix;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                j = int'(ult) + k;
                if (j >= N) j = j - N;
                ix = IDW'(j);
                if (!achou && req[ix]) begin
                    venc  = ix;
                    achou = 1'b1;
                end
            end
        end
    end

    assign outros = |(req & ~grant);
    assign limite = (HOLD_MAX != 0) && (cnt == CMAX) && outros;
    assign soltar = done || !req[sel] || limite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= OCIOSO;
        end else begin
            st <= st_d;
        end
    end

    always_comb begin
        st_d = st;
        unique case (st)
            OCIOSO:    if (|req) st_d = CONCEDIDO;
            CONCEDIDO: if (soltar) st_d = LIBERA;
            LIBERA:    st_d = OCIOSO;
            default:   st_d = OCIOSO;
        endcase
    end

    // Owner is frozen once granted; only a fresh grant from idle picks anew.
    always_comb begin
        ativo_d = 1'b0;
        sel_d   = '0;
        grant_d = '0;
        if (st_d == CONCEDIDO) begin
            ativo_d        = 1'b1;
            sel_d          = (st == OCIOSO) ? venc : sel;
            grant_d[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ativo <= 1'b0;
            sel   <= '0;
            grant <= '0;
            ult   <= IDW'(N - 1);
            cnt   <= '0;
        end else begin
            ativo <= ativo_d;
            sel   <= sel_d;
            grant <= grant_d;
            if (st == OCIOSO && st_d == CONCEDIDO) begin
                ult <= venc;
                cnt <= '0;
            end else if (st == CONCEDIDO && cnt != CMAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_arbitro_interfaces.sv
// Bench for arbitro_interfaces: directed scenarios plus a randomized sweep
// against a grant-level model, over six parameter sets sharing one clock.
module tb_arbitro_interfaces;

    logic             clk;
    logic             rst_n;
    logic [3:0]       rq4;
    logic [4:0]       rq5;
    logic             dn4;
    logic             dn5;
    logic [5:0]       at;
    logic [5:0][2:0]  sl;
    logic [5:0][4:0]  gr;

    int checks;
    int errors;

    int m_n[6]    = '{4, 4, 4, 4, 5, 5};
    int m_mode[6] = '{0, 1, 0, 1, 0, 1};
    int m_hold[6] = '{0, 0, 5, 5, 3, 3};
    int own[6];
    int age[6];
    int last[6];
    bit gap[6];

    arbitro_interfaces #(.N(4), .MODE(0), .HOLD_MAX(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req(rq4), .done(dn4),
        .ativo(at[0]), .sel(sl[0][1:0]), .grant(gr[0][3:0]));
    arbitro_interfaces #(.N(4), .MODE(1), .HOLD_MAX(0)) u1 (
        .clk(clk), .rst_n(rst_n), .req(rq4), .done(dn4),
        .ativo(at[1]), .sel(sl[1][1:0]), .grant(gr[1][3:0]));
    arbitro_interfaces #(.N(4), .MODE(0), .HOLD_MAX(5)) u2 (
        .clk(clk), .rst_n(rst_n), .req(rq4), .done(dn4),
        .ativo(at[2]), .sel(sl[2][1:0]), .grant(gr[2][3:0]));
    arbitro_interfaces #(.N(4), .MODE(1), .HOLD_MAX(5)) u3 (
        .clk(clk), .rst_n(rst_n), .req(rq4), .done(dn4),
        .ativo(at[3]), .sel(sl[3][1:0]), .grant(gr[3][3:0]));
    arbitro_interfaces #(.N(5), .MODE(0), .HOLD_MAX(3)) u4 (
        .clk(clk), .rst_n(rst_n), .req(rq5), .done(dn5),
        .ativo(at[4]), .sel(sl[4]), .grant(gr[4]));
    arbitro_interfaces #(.N(5), .MODE(1), .HOLD_MAX(3)) u5 (
        .clk(clk), .rst_n(rst_n), .req(rq5), .done(dn5),
        .ativo(at[5]), .sel(sl[5]), .grant(gr[5]));

    for (genvar k = 0; k < 4; k++) begin : g_pad
        assign sl[k][2] = 1'b0;
        assign gr[k][4] = 1'b0;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit bt(logic [4:0] v, int i);
        return ((v >> i) & 5'd1) != 5'd0;
    endfunction

    function automatic int pick(int k, logic [4:0] r);
        int w;
        int i;
        w = -1;
        if (m_mode[k] == 0) begin
            for (int b = 0; b < m_n[k]; b++)
                if (bt(r, b)) w = b;
        end else begin
            for (int s = 1; s <= m_n[k]; s++) begin
                i = (last[k] + s) % m_n[k];
                if (w < 0 && bt(r, i)) w = i;
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) begin
            own[k]  = -1;
            age[k]  = 0;
            last[k] = m_n[k] - 1;
            gap[k]  = 1'b0;
        end
    endtask

    // A grant lasts until done, owner drop, or HOLD_MAX cycles under contention;
    // then one dead cycle and one idle cycle before the next pick.
    task automatic model_step();
        logic [4:0] r;
        logic       d;
        bit         oth;
        for (int k = 0; k < 6; k++) begin
            r = (k < 4) ? {1'b0, rq4} : rq5;
            d = (k < 4) ? dn4 : dn5;
            if (gap[k]) begin
                gap[k] = 1'b0;
            end else if (own[k] < 0) begin
                if (r != 5'd0) begin
                    own[k]  = pick(k, r);
                    last[k] = own[k];
                    age[k]  = 1;
                end
            end else begin
                oth = (r & ~(5'd1 << own[k])) != 5'd0;
                if (d || !bt(r, own[k]) ||
                    (m_hold[k] != 0 && age[k] >= m_hold[k] && oth)) begin
                    own[k] = -1;
                    gap[k] = 1'b1;
                end else begin
                    age[k] = age[k] + 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rq4   = '0;
        rq5   = '0;
        dn4   = 1'b0;
        dn5   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rq4 = '0; rq5 = '0; dn4 = 1'b0; dn5 = 1'b0;
        model_reset();
        #2;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({at[k], sl[k], gr[k]} !== 9'd0) begin
                errors++;
                $display("FAIL reset_init u%0d: got a=%b s=%0d g=%b want 0",
                         k, at[k], sl[k], gr[k]);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rq4 = 4'b0100;
        tick();
        checks++;
        if ({at[0], sl[0], gr[0]} !== {1'b1, 3'd2, 5'b00100}) begin
            errors++;
            $display("FAIL reset_pre u0: got a=%b s=%0d g=%b want 1/2/00100",
                     at[0], sl[0], gr[0]);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({at[k], sl[k], gr[k]} !== 9'd0) begin
                errors++;
                $display("FAIL reset_async u%0d: got a=%b s=%0d g=%b want 0",
                         k, at[k], sl[k], gr[k]);
            end
        end
        rst_n = 1'b1;
        rq4 = 4'b0001;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({at[k], sl[k], gr[k]} !== {1'b1, 3'd0, 5'b00001}) begin
                errors++;
                $display("FAIL reset_post u%0d: got a=%b s=%0d g=%b want 1/0/00001",
                         k, at[k], sl[k], gr[k]);
            end
        end
    endtask

    task automatic test_fixed();
        do_reset();
        rq4 = 4'b0011;
        tick();
        checks++;
        if ({at[0], sl[0], gr[0]} !== {1'b1, 3'd1, 5'b00010}) begin
            errors++;
            $display("FAIL fixed_grant: got a=%b s=%0d g=%b want 1/1/00010",
                     at[0], sl[0], gr[0]);
        end
        dn4 = 1'b1;
        tick();
        dn4 = 1'b0;
        checks++;
        if ({at[0], sl[0], gr[0]} !== 9'd0) begin
            errors++;
            $display("FAIL fixed_libera: got a=%b s=%0d g=%b want 0",
                     at[0], sl[0], gr[0]);
        end
        tick();
        checks++;
        if ({at[0], sl[0], gr[0]} !== 9'd0) begin
            errors++;
            $display("FAIL fixed_ocioso: got a=%b s=%0d g=%b want 0",
                     at[0], sl[0], gr[0]);
        end
        tick();
        checks++;
        if ({at[0], sl[0], gr[0]} !== {1'b1, 3'd1, 5'b00010}) begin
            errors++;
            $display("FAIL fixed_regrant: got a=%b s=%0d g=%b want 1/1/00010",
                     at[0], sl[0], gr[0]);
        end
    endtask

    task automatic test_round_robin();
        int         exp_sel[5] = '{0, 1, 2, 3, 0};
        logic [3:0] served;
        do_reset();
        served = '0;
        rq4 = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            checks++;
            if (at[1] !== 1'b1 || sl[1] !== 3'(exp_sel[g])) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got a=%b s=%0d want 1/%0d",
                         g, at[1], sl[1], exp_sel[g]);
            end
            checks++;
            if (sl[0] !== 3'd3) begin
                errors++;
                $display("FAIL rr_fixed_ref[%0d]: got s=%0d want 3", g, sl[0]);
            end
            if (g < 4) served[sl[1][1:0]] = 1'b1;
            dn4 = 1'b1;
            tick();
            dn4 = 1'b0;
            tick();
        end
        checks++;
        if (served !== 4'b1111) begin
            errors++;
            $display("FAIL rr_fair: got served=%b want 1111", served);
        end
    endtask

    task automatic test_hold_limit();
        int n2;
        int n3;
        do_reset();
        rq4 = 4'b1000;
        tick();
        checks++;
        if ({at[2], sl[2], at[3], sl[3]} !== {1'b1, 3'd3, 1'b1, 3'd3}) begin
            errors++;
            $display("FAIL hold_first: got u2=%b/%0d u3=%b/%0d want 1/3 1/3",
                     at[2], sl[2], at[3], sl[3]);
        end
        rq4 = 4'b1010;
        n2 = 1;
        n3 = 1;
        repeat (6) begin
            tick();
            n2 += int'(at[2]);
            n3 += int'(at[3]);
        end
        checks++;
        if (n2 != 5 || n3 != 5) begin
            errors++;
            $display("FAIL hold_len: got u2=%0d u3=%0d cycles want 5", n2, n3);
        end
        checks++;
        if (at[2] !== 1'b0 || at[3] !== 1'b0) begin
            errors++;
            $display("FAIL hold_gap: got u2=%b u3=%b want 0", at[2], at[3]);
        end
        tick();
        checks++;
        if ({at[2], sl[2], gr[2]} !== {1'b1, 3'd3, 5'b01000}) begin
            errors++;
            $display("FAIL hold_next_fixed: got a=%b s=%0d g=%b want 1/3/01000",
                     at[2], sl[2], gr[2]);
        end
        checks++;
        if ({at[3], sl[3], gr[3]} !== {1'b1, 3'd1, 5'b00010}) begin
            errors++;
            $display("FAIL hold_next_rr: got a=%b s=%0d g=%b want 1/1/00010",
                     at[3], sl[3], gr[3]);
        end
        checks++;
        if ({at[0], sl[0]} !== {1'b1, 3'd3}) begin
            errors++;
            $display("FAIL hold_unlimited: got a=%b s=%0d want 1/3", at[0], sl[0]);
        end
    endtask

    task automatic test_owner_drop();
        do_reset();
        rq4 = 4'b0100;
        tick();
        tick();
        checks++;
        if ({at[0], sl[0], gr[0]} !== {1'b1, 3'd2, 5'b00100}) begin
            errors++;
            $display("FAIL drop_grant: got a=%b s=%0d g=%b want 1/2/00100",
                     at[0], sl[0], gr[0]);
        end
        rq4 = 4'b0000;
        tick();
        checks++;
        if ({at[0], sl[0], gr[0]} !== 9'd0) begin
            errors++;
            $display("FAIL drop_release: got a=%b s=%0d g=%b want 0",
                     at[0], sl[0], gr[0]);
        end
        tick();
        rq4 = 4'b0100;
        dn4 = 1'b1;
        tick();
        dn4 = 1'b0;
        checks++;
        if ({at[0], sl[0], gr[0]} !== {1'b1, 3'd2, 5'b00100}) begin
            errors++;
            $display("FAIL drop_done_idle: got a=%b s=%0d g=%b want 1/2/00100",
                     at[0], sl[0], gr[0]);
        end
        tick();
        checks++;
        if (at[0] !== 1'b1) begin
            errors++;
            $display("FAIL drop_done_ignored: got a=%b want 1", at[0]);
        end
    endtask

    task automatic test_sweep();
        int         es;
        logic [4:0] eg;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(5) == 0) rq4 = 4'($urandom);
            if ($urandom_range(5) == 0) rq5 = 5'($urandom);
            dn4 = ($urandom_range(7) == 0);
            dn5 = ($urandom_range(7) == 0);
            tick();
            for (int k = 0; k < 6; k++) begin
                es = (own[k] < 0) ? 0 : own[k];
                eg = (own[k] < 0) ? 5'd0 : (5'd1 << own[k]);
                checks++;
                if ({at[k], sl[k], gr[k]} !== {own[k] >= 0, 3'(es), eg}) begin
                    errors++;
                    if (errors < 30)
                        $display("FAIL sweep c%0d u%0d: got a=%b s=%0d g=%b want %b/%0d/%b",
                                 c, k, at[k], sl[k], gr[k], own[k] >= 0, es, eg);
                end
                checks++;
                if (!$onehot0(gr[k]) || at[k] !== |gr[k] ||
                    int'(sl[k]) >= m_n[k] || gr[k][sl[k]] !== at[k]) begin
                    errors++;
                    if (errors < 30)
                        $display("FAIL invariant c%0d u%0d: got a=%b s=%0d g=%b",
                                 c, k, at[k], sl[k], gr[k]);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_hold_limit();
        test_owner_drop();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
